scr1_dmem_arbiter: RTL

//  Two-master arbiter sharing one SCR1 DMEM-protocol slave port (the dmem router input) between

---
 rtl/scr1_dmem_arb_pkg.sv | 35 +++
 rtl/scr1_dmem_arbiter_if.sv | 24 ++
 rtl/scr1_dmem_arb_sel.sv | 60 ++++++
 rtl/scr1_dmem_arbiter.sv | 102 ++++++++++
 4 files changed

// File: rtl/scr1_dmem_arb_pkg.sv
// Shared types for the two-master DMEM arbiter: memory-protocol enums,
// bus widths and the arbiter FSM / master-select encodings.
package scr1_dmem_arb_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } type_scr1_dmem_arb_fsm_e;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } type_scr1_dmem_arb_sel_e;

endpackage

// File: rtl/scr1_dmem_arbiter_if.sv
// One DMEM-protocol port: request/command phase plus the response/read-data phase.
interface scr1_dmem_arbiter_if;
    import scr1_dmem_arb_pkg::*;

    logic                          req;
    type_scr1_mem_cmd_e            cmd;
    type_scr1_mem_width_e          width;
    logic [SCR1_DMEM_AWIDTH-1:0]   addr;
    logic [SCR1_DMEM_DWIDTH-1:0]   wdata;
    logic                          req_ack;
    logic [SCR1_DMEM_DWIDTH-1:0]   rdata;
    type_scr1_mem_resp_e           resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );

endinterface

// File: rtl/scr1_dmem_arb_sel.sv
// Winner selection for the DMEM arbiter: round-robin or fixed priority with an
// m0 burst limit that guarantees m1 a grant after MAX_BURST back-to-back m0 wins.
module scr1_dmem_arb_sel
    import scr1_dmem_arb_pkg::*;
#(
    parameter int unsigned SCR1_ARB_RR        = 1,
    parameter int unsigned SCR1_ARB_MAX_BURST = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req_i,
    input  logic                    m1_req_i,
    input  logic                    transfer_i,
    output type_scr1_dmem_arb_sel_e winner_o
);

    localparam logic [3:0] MAX_BURST = 4'(SCR1_ARB_MAX_BURST);

    type_scr1_dmem_arb_sel_e last_q, last_d;
    logic [3:0]              burst_cnt_q, burst_cnt_d;

    always_comb begin
        winner_o = M0;
        unique case ({m1_req_i, m0_req_i})
            2'b01:   winner_o = M0;
            2'b10:   winner_o = M1;
            2'b11: begin
                if (SCR1_ARB_RR != 0) winner_o = (last_q == M0) ? M1 : M0;
                else                  winner_o = (burst_cnt_q == MAX_BURST) ? M1 : M0;
            end
            default: winner_o = M0;
        endcase
    end

    // History only advances on an actual transfer, never on a mere request.
    always_comb begin
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        if (transfer_i) begin
            last_d = winner_o;
            if (SCR1_ARB_RR == 0) begin
                if ((winner_o == M0) && m1_req_i)
                    burst_cnt_d = (burst_cnt_q == MAX_BURST) ? MAX_BURST : burst_cnt_q + 4'd1;
                else
                    burst_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= M1;
            burst_cnt_q <= 4'd0;
        end else begin
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: rtl/scr1_dmem_arbiter.sv
// Two-master arbiter in front of the DMEM router: one outstanding transfer,
// back-to-back accepts when the current data phase completes with RDY_OK.
module scr1_dmem_arbiter
    import scr1_dmem_arb_pkg::*;
#(
    parameter int unsigned SCR1_ARB_RR        = 1,
    parameter int unsigned SCR1_ARB_MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    scr1_dmem_arbiter_if.slave   m0_if,
    scr1_dmem_arbiter_if.slave   m1_if,
    scr1_dmem_arbiter_if.master  slv_if
);

    type_scr1_dmem_arb_fsm_e fsm_q, fsm_d;
    type_scr1_dmem_arb_sel_e owner_q, owner_d;
    type_scr1_dmem_arb_sel_e winner;
    logic                    window;
    logic                    transfer;

    scr1_dmem_arb_sel #(
        .SCR1_ARB_RR        (SCR1_ARB_RR),
        .SCR1_ARB_MAX_BURST (SCR1_ARB_MAX_BURST)
    ) i_sel (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req_i   (m0_if.req),
        .m1_req_i   (m1_if.req),
        .transfer_i (transfer),
        .winner_o   (winner)
    );

    // Gating with rst_n keeps slv_req and req_ack quiet while reset is held.
    assign window   = rst_n & ((fsm_q == IDLE) |
                               ((fsm_q == DATA) & (slv_if.resp == SCR1_MEM_RESP_RDY_OK)));
    assign transfer = slv_if.req & slv_if.req_ack;

    always_comb begin
        slv_if.req    = 1'b0;
        slv_if.cmd    = m0_if.cmd;
        slv_if.width  = m0_if.width;
        slv_if.addr   = m0_if.addr;
        slv_if.wdata  = m0_if.wdata;
        m0_if.req_ack = 1'b0;
        m1_if.req_ack = 1'b0;
        if (winner == M1) begin
            slv_if.cmd   = m1_if.cmd;
            slv_if.width = m1_if.width;
            slv_if.addr  = m1_if.addr;
            slv_if.wdata = m1_if.wdata;
        end
        if (window) begin
            if (winner == M1) begin
                slv_if.req    = m1_if.req;
                m1_if.req_ack = slv_if.req_ack & m1_if.req;
            end else begin
                slv_if.req    = m0_if.req;
                m0_if.req_ack = slv_if.req_ack & m0_if.req;
            end
        end
    end

    // Responses are a zero-latency pass-through steered to the data-phase owner.
    always_comb begin
        m0_if.rdata = slv_if.rdata;
        m1_if.rdata = slv_if.rdata;
        m0_if.resp  = ((fsm_q == DATA) && (owner_q == M0)) ? slv_if.resp : SCR1_MEM_RESP_NOTRDY;
        m1_if.resp  = ((fsm_q == DATA) && (owner_q == M1)) ? slv_if.resp : SCR1_MEM_RESP_NOTRDY;
    end

    always_comb begin
        fsm_d   = fsm_q;
        owner_d = owner_q;
        if (transfer) begin
            fsm_d   = DATA;
            owner_d = winner;
        end else if ((fsm_q == DATA) && (slv_if.resp != SCR1_MEM_RESP_NOTRDY)) begin
            fsm_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            owner_q <= M0;
        end else begin
            fsm_q   <= fsm_d;
            owner_q <= owner_d;
        end
    end

`ifdef SCR1_TRGT_SIMULATION
    a_ack_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(m0_if.req_ack && m1_if.req_ack));
    a_resp_m0_owner: assert property (@(posedge clk) disable iff (!rst_n)
        (m0_if.resp == SCR1_MEM_RESP_NOTRDY) || ((fsm_q == DATA) && (owner_q == M0)));
    a_resp_m1_owner: assert property (@(posedge clk) disable iff (!rst_n)
        (m1_if.resp == SCR1_MEM_RESP_NOTRDY) || ((fsm_q == DATA) && (owner_q == M1)));
`endif

endmodule
